flag_event_queue: RTL and testbench
===================================

// Module: flag_event_queue
//
// PURPOSE
//  Downstream consumer of the clock-domain-2 flag pulse produced by the flag synchronizer.
//  Counts single-cycle flag pulses and re-issues them one at a time on a valid/ready handshake.
//  A busy consumer therefore never loses back-to-back events.
//  Saturating pending counter, sticky overflow flag, optional hold-off gap between issued events.
//
// PARAMETERS
//  COUNT_WIDTH     4  width of pending counter; capacity = 2**COUNT_WIDTH-1 events (>=1)
//  HOLDOFF_CYCLES  0  idle cycles forced on event_valid after each accepted event (0 = none)
//
// PORTS
//  clock_domain_2   in   1            sole clock; all logic on rising edge
//  reset_n          in   1            asynchronous, active-low reset
//  flag_domain_2    in   1            event pulse; each high cycle = one event
//  event_valid      out  1            an event is offered downstream
//  event_ready      in   1            downstream accepts; handshake = event_valid & event_ready
//  pending_count    out  COUNT_WIDTH  events counted but not yet accepted (registered)
//  overflow         out  1            sticky: an event was dropped at saturation
//  clear_overflow   in   1            synchronous clear of overflow
//  busy             out  1            state != IDLE or pending_count != 0
//
// BEHAVIOUR
//  Reset: async assert -> state IDLE; pending_count=0, event_valid=0, overflow=0, busy=0, timer=0.
//   Flags during reset are ignored; release is synchronous to clock_domain_2 edge; no events survive reset.
//  Counter, per edge (inc = flag_domain_2, dec = handshake):
//   inc&!dec: +1 if below max; at max, hold and set overflow (event dropped).
//   !inc&dec: -1.  inc&dec: unchanged, also at max (freed slot is reused, no overflow).
//   Counter never wraps in either direction; dec with count 0 is impossible by construction.
//  overflow: set has priority over clear_overflow in same cycle; otherwise cleared by clear_overflow.
//  FSM (registered state, event_valid = state==ISSUE, Moore output):
//   IDLE    -> ISSUE when next pending_count != 0. Flag high in cycle k -> event_valid high in cycle k+1.
//   ISSUE   hold event_valid until handshake (valid never drops without handshake).
//           On handshake: HOLDOFF_CYCLES>0 -> HOLDOFF, timer loaded HOLDOFF_CYCLES-1;
//           else next pending_count!=0 -> stay ISSUE (one event per cycle), else IDLE.
//   HOLDOFF event_valid=0; timer decrements each cycle; flags still counted.
//           At timer==0: next pending_count!=0 -> ISSUE, else IDLE.
//           Gap = exactly HOLDOFF_CYCLES low cycles between handshake and next valid.
//  pending_count includes the event currently offered; it drops on the handshake edge.
//  event_ready while event_valid=0 has no effect.
//  Timer width = $clog2(HOLDOFF_CYCLES+1), minimum 1; unused when HOLDOFF_CYCLES=0.
//
// STRUCTURE
//  Package flag_sync_pkg: typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HOLDOFF} flag_queue_state_t.
//  Single module, no sub-modules: one always_ff for state/counter/timer/overflow, one always_comb next-state.
//  Counter next-value computed once in always_comb; FSM and overflow both use it.
//
// TESTING
//  1 Single pulse, ready=1, HOLDOFF=0: flag cycle 5 -> valid cycles 6 only; count 1 then 0; busy clears cycle 7.
//  2 Burst 3 pulses (cycles 5-7), ready=0 until cycle 12: count=3; valid held 6-12; ready=1 -> 3 handshakes cycles 12-14, count 0.
//  3 COUNT_WIDTH=2, ready=0, 4 pulses: count saturates at 3, overflow=1 after 4th;
//    clear_overflow same cycle as 5th pulse -> overflow stays 1; clear alone next cycle -> 0.
//  4 Saturated (3), flag & handshake same cycle: count stays 3, overflow stays 0.
//  5 HOLDOFF_CYCLES=2, 2 pulses, ready=1: valid high, low 2 cycles, high again; flag during HOLDOFF counted.
//  6 Reset asserted mid-ISSUE with count=2: outputs zero immediately (async); after release no valid.

Source files
------------

// File: rtl/flag_sync_pkg.sv
// Shared types for the clock-domain-2 flag event queue.
package flag_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLDOFF
    } flag_queue_state_t;

endpackage

// File: rtl/flag_event_queue.sv
// Counts single-cycle flag pulses and re-issues them one at a time on a valid/ready
// handshake, with a saturating pending counter, sticky overflow and optional hold-off gap.
module flag_event_queue
    import flag_sync_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH    = 4,
    parameter int unsigned HOLDOFF_CYCLES = 0
) (
    input  logic                   clock_domain_2,
    input  logic                   reset_n,
    input  logic                   flag_domain_2,
    output logic                   event_valid,
    input  logic                   event_ready,
    output logic [COUNT_WIDTH-1:0] pending_count,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic                   busy
);

    localparam int unsigned TIMER_WIDTH =
        (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
    localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD =
        TIMER_WIDTH'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    flag_queue_state_t       state_q, state_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
    logic                    overflow_q, overflow_d;
    logic                    handshake;
    logic                    drop;

    assign event_valid   = (state_q == ST_ISSUE);
    assign handshake     = event_valid & event_ready;
    assign pending_count = count_q;
    assign overflow      = overflow_q;
    assign busy          = (state_q != ST_IDLE) || (count_q != '0);

    always_comb begin
        count_d    = count_q;
        drop       = 1'b0;
        state_d    = state_q;
        timer_d    = timer_q;
        overflow_d = overflow_q;

        // Simultaneous inc and dec leaves the count unchanged, so a saturated
        // queue reuses the freed slot without flagging overflow.
        if (flag_domain_2 && !handshake) begin
            if (count_q == COUNT_MAX) begin
                drop = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (!flag_domain_2 && handshake) begin
            count_d = count_q - 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (count_d != '0) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (handshake) begin
                    if (HOLDOFF_CYCLES > 0) begin
                        state_d = ST_HOLDOFF;
                        timer_d = TIMER_LOAD;
                    end else if (count_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (timer_q == '0) begin
                    state_d = (count_d != '0) ? ST_ISSUE : ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_domain_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            timer_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_flag_event_queue.sv
// Directed self-checking bench: three queue configurations sharing one clock and reset.
module tb_flag_event_queue;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    // A: COUNT_WIDTH=4, no hold-off
    logic       flag_a = 0, ready_a = 0, clr_a = 0;
    logic       valid_a, ovf_a, busy_a;
    logic [3:0] count_a;
    // B: COUNT_WIDTH=2, no hold-off
    logic       flag_b = 0, ready_b = 0, clr_b = 0;
    logic       valid_b, ovf_b, busy_b;
    logic [1:0] count_b;
    // C: COUNT_WIDTH=4, hold-off of 2
    logic       flag_c = 0, ready_c = 0, clr_c = 0;
    logic       valid_c, ovf_c, busy_c;
    logic [3:0] count_c;

    flag_event_queue #(.COUNT_WIDTH(4), .HOLDOFF_CYCLES(0)) dut_a (
        .clock_domain_2(clk), .reset_n(rst_n), .flag_domain_2(flag_a),
        .event_valid(valid_a), .event_ready(ready_a), .pending_count(count_a),
        .overflow(ovf_a), .clear_overflow(clr_a), .busy(busy_a)
    );
    flag_event_queue #(.COUNT_WIDTH(2), .HOLDOFF_CYCLES(0)) dut_b (
        .clock_domain_2(clk), .reset_n(rst_n), .flag_domain_2(flag_b),
        .event_valid(valid_b), .event_ready(ready_b), .pending_count(count_b),
        .overflow(ovf_b), .clear_overflow(clr_b), .busy(busy_b)
    );
    flag_event_queue #(.COUNT_WIDTH(4), .HOLDOFF_CYCLES(2)) dut_c (
        .clock_domain_2(clk), .reset_n(rst_n), .flag_domain_2(flag_c),
        .event_valid(valid_c), .event_ready(ready_c), .pending_count(count_c),
        .overflow(ovf_c), .clear_overflow(clr_c), .busy(busy_c)
    );

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flag_a = 1'b1;
        repeat (3) tick();
        flag_a = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if ({valid_a, count_a, ovf_a, busy_a} !== 7'b0) $display("FAIL reset_a got %b want 0", {valid_a, count_a, ovf_a, busy_a}); else passes++;
        checks++; if ({valid_b, count_b, ovf_b, busy_b} !== 5'b0) $display("FAIL reset_b got %b want 0", {valid_b, count_b, ovf_b, busy_b}); else passes++;
        checks++; if ({valid_c, count_c, ovf_c, busy_c} !== 7'b0) $display("FAIL reset_c got %b want 0", {valid_c, count_c, ovf_c, busy_c}); else passes++;
    endtask

    task automatic test_single_pulse();
        ready_a = 1'b1;
        flag_a = 1'b1;
        tick();
        flag_a = 1'b0;
        checks++; if ({valid_a, count_a, busy_a} !== {1'b1, 4'd1, 1'b1}) $display("FAIL single_issue got v=%b c=%0d b=%b want v=1 c=1 b=1", valid_a, count_a, busy_a); else passes++;
        tick();
        checks++; if ({valid_a, count_a, busy_a} !== {1'b0, 4'd0, 1'b0}) $display("FAIL single_done got v=%b c=%0d b=%b want v=0 c=0 b=0", valid_a, count_a, busy_a); else passes++;
        ready_a = 1'b0;
    endtask

    task automatic test_burst();
        ready_a = 1'b0;
        flag_a = 1'b1;
        repeat (3) tick();
        flag_a = 1'b0;
        checks++; if ({valid_a, count_a} !== {1'b1, 4'd3}) $display("FAIL burst_count got v=%b c=%0d want v=1 c=3", valid_a, count_a); else passes++;
        repeat (4) tick();
        checks++; if ({valid_a, count_a} !== {1'b1, 4'd3}) $display("FAIL burst_hold got v=%b c=%0d want v=1 c=3", valid_a, count_a); else passes++;
        ready_a = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tick();
            checks++; if ({valid_a, count_a} !== {(i != 0), 4'(i)}) $display("FAIL burst_drain%0d got v=%b c=%0d want v=%b c=%0d", i, valid_a, count_a, (i != 0), i); else passes++;
        end
        ready_a = 1'b0;
    endtask

    task automatic test_saturate();
        ready_b = 1'b0;
        flag_b = 1'b1;
        repeat (3) tick();
        checks++; if ({count_b, ovf_b} !== {2'd3, 1'b0}) $display("FAIL sat_fill got c=%0d o=%b want c=3 o=0", count_b, ovf_b); else passes++;
        tick();
        checks++; if ({count_b, ovf_b} !== {2'd3, 1'b1}) $display("FAIL sat_drop got c=%0d o=%b want c=3 o=1", count_b, ovf_b); else passes++;
        clr_b = 1'b1;
        tick();
        checks++; if (ovf_b !== 1'b1) $display("FAIL sat_set_wins got o=%b want o=1", ovf_b); else passes++;
        flag_b = 1'b0;
        tick();
        clr_b = 1'b0;
        checks++; if ({count_b, ovf_b} !== {2'd3, 1'b0}) $display("FAIL sat_clear got c=%0d o=%b want c=3 o=0", count_b, ovf_b); else passes++;
    endtask

    task automatic test_back_to_back();
        flag_b = 1'b1;
        ready_b = 1'b1;
        tick();
        flag_b = 1'b0;
        checks++; if ({valid_b, count_b, ovf_b} !== {1'b1, 2'd3, 1'b0}) $display("FAIL b2b_sat got v=%b c=%0d o=%b want v=1 c=3 o=0", valid_b, count_b, ovf_b); else passes++;
        repeat (3) tick();
        checks++; if ({valid_b, count_b, busy_b} !== {1'b0, 2'd0, 1'b0}) $display("FAIL b2b_drain got v=%b c=%0d b=%b want v=0 c=0 b=0", valid_b, count_b, busy_b); else passes++;
        ready_b = 1'b0;
    endtask

    task automatic test_holdoff();
        logic       exp_v [10];
        logic [3:0] exp_c [10];
        // Pulses in two consecutive cycles, a third during hold-off.
        exp_v = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
        exp_c = '{1, 1, 2, 2, 1, 1, 1, 0, 0, 0};
        ready_c = 1'b1;
        for (int i = 0; i < 10; i++) begin
            flag_c = (i <= 2);
            tick();
            checks++; if ({valid_c, count_c} !== {exp_v[i], exp_c[i]}) $display("FAIL holdoff_t%0d got v=%b c=%0d want v=%b c=%0d", i, valid_c, count_c, exp_v[i], exp_c[i]); else passes++;
        end
        flag_c = 1'b0;
        checks++; if (busy_c !== 1'b0) $display("FAIL holdoff_idle got b=%b want b=0", busy_c); else passes++;
        ready_c = 1'b0;
    endtask

    task automatic test_async_reset();
        ready_a = 1'b0;
        flag_a = 1'b1;
        repeat (2) tick();
        flag_a = 1'b0;
        checks++; if ({valid_a, count_a} !== {1'b1, 4'd2}) $display("FAIL rst_pre got v=%b c=%0d want v=1 c=2", valid_a, count_a); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({valid_a, count_a, ovf_a, busy_a} !== 7'b0) $display("FAIL rst_async got %b want 0", {valid_a, count_a, ovf_a, busy_a}); else passes++;
        flag_a = 1'b1;
        tick();
        flag_a = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        checks++; if ({valid_a, count_a, busy_a} !== 6'b0) $display("FAIL rst_after got v=%b c=%0d b=%b want 0", valid_a, count_a, busy_a); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_burst();
        test_saturate();
        test_back_to_back();
        test_holdoff();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
